// File: rtl/axis_pack_pkg.sv
// Shared definitions for the AXI4-Stream byte packer.
//   MAX_KEEP        : widest keep vector the helper functions accept
//   lane_idx_width  : bits needed to hold a lane count 0..K ($clog2(K+1))
//   popcount        : number of set bits in a keep vector
//   keep_mask       : contiguous low-order mask (1<<n)-1
//   pack_state_t    : packer FSM states (streaming / tail pending)
package axis_pack_pkg;

    localparam int unsigned MAX_KEEP = 128;

    function automatic int unsigned lane_idx_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    // Lane-index width for the default 64-bit (8-lane) configuration.
    localparam int unsigned LANE_IDX_W = lane_idx_width(8);

    function automatic int unsigned popcount(input logic [MAX_KEEP-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

    function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned n);
        logic [MAX_KEEP-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_KEEP; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    typedef enum logic {
        PACK_STREAM,
        PACK_TAIL
    } pack_state_t;

endpackage

// File: rtl/axis_keep_compact.sv
// Combinational byte-lane compactor.
// Moves every kept byte of tdata down to the lowest free lane, preserving
// ascending lane order; unkept lanes never contribute and unused output
// lanes are zero.
//   tdata    in   input beat data
//   tkeep    in   input byte enables (any pattern)
//   data_out out  compacted bytes in lanes 0..count-1
//   count    out  number of kept bytes
module axis_keep_compact
    import axis_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned CNT_W      = lane_idx_width(KEEP_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic [KEEP_WIDTH-1:0] tkeep,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      count
);

    always_comb begin
        int unsigned pos;
        data_out = '0;
        pos      = 0;
        // pos is the prefix sum of keep bits below lane i, i.e. the
        // destination lane of byte i.
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            if (tkeep[i]) begin
                data_out[8*pos +: 8] = tdata[8*i +: 8];
                pos++;
            end
        end
        count = CNT_W'(popcount(MAX_KEEP'(tkeep)));
    end

endmodule

// File: rtl/axis_byte_packer.sv
// AXI4-Stream byte packer: removes holes from the byte stream so that every
// output beat has all-ones tkeep, except the last beat of a frame which
// carries contiguous low-order keep bits (possibly zero for an empty frame).
// Byte order and frame boundaries are preserved.
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        input stream (tkeep may be sparse)
//   m_axis_*        packed output stream, registered (one-cycle latency)
module axis_byte_packer
    import axis_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned USER_ENABLE = 1,
    parameter int unsigned USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
);

    localparam int unsigned CNT_W = lane_idx_width(KEEP_WIDTH);
    localparam logic [CNT_W:0] K_C = (CNT_W + 1)'(KEEP_WIDTH);

    // Residual buffer holds up to K-1 bytes in its low lanes; lanes at or
    // above cnt_q are always zero so it can be OR-merged with new bytes.
    logic [DATA_WIDTH-9:0] res_q, res_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    pack_state_t           state_q, state_d;

    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic [KEEP_WIDTH-1:0] tail_keep_q, tail_keep_d;
    logic [USER_WIDTH-1:0] tail_user_q, tail_user_d;

    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [USER_WIDTH-1:0] m_user_q, m_user_d;

    logic [DATA_WIDTH-1:0]   cmp_data;
    logic [CNT_W-1:0]        cmp_cnt;
    logic [2*DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0]   merged_lo, merged_hi;
    logic [CNT_W:0]          c_total, c_over;
    logic [USER_WIDTH-1:0]   in_user;
    logic                    slot_free, accept;

    axis_keep_compact #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .CNT_W      (CNT_W)
    ) u_compact (
        .tdata    (s_axis_tdata),
        .tkeep    (s_axis_tkeep),
        .data_out (cmp_data),
        .count    (cmp_cnt)
    );

    always_comb begin
        slot_free     = !m_valid_q || m_axis_tready;
        s_axis_tready = !rst && (state_q == PACK_STREAM) && slot_free;
        accept        = s_axis_tvalid && s_axis_tready;
        in_user       = (USER_ENABLE != 0) ? s_axis_tuser : '0;

        // New bytes land directly above the residual bytes.
        merged    = (2*DATA_WIDTH)'(res_q)
                  | ((2*DATA_WIDTH)'(cmp_data) << {cnt_q, 3'b000});
        merged_lo = merged[DATA_WIDTH-1:0];
        merged_hi = merged[2*DATA_WIDTH-1:DATA_WIDTH];
        c_total   = {1'b0, cnt_q} + {1'b0, cmp_cnt};
        c_over    = c_total - K_C;
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        tail_data_d = tail_data_q;
        tail_keep_d = tail_keep_q;
        tail_user_d = tail_user_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_user_d    = m_user_q;
        m_valid_d   = m_valid_q && !m_axis_tready;

        unique case (state_q)
            PACK_STREAM: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        res_d = '0;
                        cnt_d = '0;
                        if (c_total > K_C) begin
                            // Frame overflows one beat: send a full beat
                            // now and park the remainder for next cycle.
                            m_valid_d   = 1'b1;
                            m_data_d    = merged_lo;
                            m_keep_d    = '1;
                            m_last_d    = 1'b0;
                            m_user_d    = in_user;
                            tail_data_d = merged_hi;
                            tail_keep_d = KEEP_WIDTH'(keep_mask(32'(c_over)));
                            tail_user_d = in_user;
                            state_d     = PACK_TAIL;
                        end else begin
                            m_valid_d = 1'b1;
                            m_data_d  = merged_lo;
                            m_keep_d  = KEEP_WIDTH'(keep_mask(32'(c_total)));
                            m_last_d  = 1'b1;
                            m_user_d  = in_user;
                        end
                    end else if (c_total >= K_C) begin
                        m_valid_d = 1'b1;
                        m_data_d  = merged_lo;
                        m_keep_d  = '1;
                        m_last_d  = 1'b0;
                        m_user_d  = in_user;
                        res_d     = merged_hi[DATA_WIDTH-9:0];
                        cnt_d     = c_over[CNT_W-1:0];
                    end else begin
                        res_d = merged_lo[DATA_WIDTH-9:0];
                        cnt_d = c_total[CNT_W-1:0];
                    end
                end
            end
            PACK_TAIL: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = tail_data_q;
                    m_keep_d  = tail_keep_q;
                    m_last_d  = 1'b1;
                    m_user_d  = tail_user_q;
                    cnt_d     = '0;
                    state_d   = PACK_STREAM;
                end
            end
            default: begin
                state_d = PACK_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PACK_STREAM;
            res_q       <= '0;
            cnt_q       <= '0;
            tail_data_q <= '0;
            tail_keep_q <= '0;
            tail_user_q <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            tail_data_q <= tail_data_d;
            tail_keep_q <= tail_keep_d;
            tail_user_q <= tail_user_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_user_q    <= m_user_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer (32-bit data, 4 lanes).
// Expected output beats come either from fixed constants or from a
// byte-queue reference model of the packing rules.
module tb_axis_byte_packer;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [0:0]    s_axis_tuser = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;

    axis_byte_packer #(
        .DATA_WIDTH  (DW),
        .KEEP_WIDTH  (KW),
        .USER_ENABLE (1),
        .USER_WIDTH  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    beat_t       exp_q[$];
    logic [7:0]  byte_q[$];
    logic        use_model = 1'b0;
    int unsigned rdy_mode  = 0;   // 0: ready high, 1: random, 2: ready low
    logic        want_valid = 1'b0;
    logic        accepted;

    logic [DW-1:0] drv_data = '0;
    logic [KW-1:0] drv_keep = '0;
    logic          drv_valid = 1'b0;
    logic          drv_last = 1'b0;
    logic          drv_user = 1'b0;

    task check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        exp_q.push_back(b);
    endtask

    // Reference model: bytes in order; K bytes form a full beat; the last
    // input beat flushes whatever remains (0..K bytes) as the frame end.
    task model_emit(input int unsigned n, input logic l, input logic u);
        beat_t b;
        b.data = '0;
        for (int unsigned i = 0; i < n; i++) begin
            b.data[8*i +: 8] = byte_q.pop_front();
        end
        b.keep = KW'((1 << n) - 1);
        b.last = l;
        b.user = u;
        if (use_model) begin
            exp_q.push_back(b);
        end
        want_valid = 1'b1;
    endtask

    task model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
        for (int unsigned i = 0; i < KW; i++) begin
            if (k[i]) begin
                byte_q.push_back(d[8*i +: 8]);
            end
        end
        while (byte_q.size() > KW || (!l && byte_q.size() == KW)) begin
            model_emit(KW, 1'b0, u);
        end
        if (l) begin
            model_emit(byte_q.size(), 1'b1, u);
        end
    endtask

    task tick();
        logic lat_pending;
        @(negedge clk);
        s_axis_tvalid = drv_valid;
        s_axis_tdata  = drv_data;
        s_axis_tkeep  = drv_keep;
        s_axis_tlast  = drv_last;
        s_axis_tuser  = drv_user;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
        #1;
        lat_pending = want_valid;
        want_valid  = 1'b0;
        if (lat_pending) begin
            check_eq("latency_valid", m_axis_tvalid, 1);
        end
        if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", m_axis_tvalid, 0);
            end else begin
                check_eq("out_data", m_axis_tdata, exp_q[0].data);
                check_eq("out_keep", m_axis_tkeep, exp_q[0].keep);
                check_eq("out_last", m_axis_tlast, exp_q[0].last);
                check_eq("out_user", m_axis_tuser, exp_q[0].user);
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
        accepted = s_axis_tvalid && s_axis_tready;
        if (accepted) begin
            model_accept(s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser[0]);
        end
    endtask

    task send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                   input logic u, output int unsigned waited);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_keep  = k;
        drv_last  = l;
        drv_user  = u;
        waited    = 0;
        accepted  = 1'b0;
        while (!accepted && waited < 100) begin
            tick();
            waited++;
        end
        if (!accepted) begin
            check_eq("accept_timeout", waited, 0);
        end
        drv_valid = 1'b0;
    endtask

    task drain();
        int unsigned n;
        rdy_mode = 0;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task do_reset();
        @(negedge clk);
        rst = 1'b1;
        drv_valid = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        check_eq("rst_s_ready", s_axis_tready, 0);
        @(negedge clk);
        #1;
        check_eq("rst_valid", m_axis_tvalid, 0);
        check_eq("rst_data", m_axis_tdata, 0);
        check_eq("rst_keep", m_axis_tkeep, 0);
        check_eq("rst_last", m_axis_tlast, 0);
        check_eq("rst_user", m_axis_tuser, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        byte_q.delete();
        want_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        int unsigned nb;
        logic [KW-1:0] k;

        do_reset();

        // 1: full beats pass straight through
        use_model = 1'b0;
        rdy_mode  = 0;
        push_exp(32'h03020100, 4'hF, 1'b0, 1'b0);
        push_exp(32'h07060504, 4'hF, 1'b0, 1'b0);
        push_exp(32'h0B0A0908, 4'hF, 1'b1, 1'b0);
        send_beat(32'h03020100, 4'hF, 1'b0, 1'b0, w); check_eq("t1_wait0", w, 1);
        send_beat(32'h07060504, 4'hF, 1'b0, 1'b0, w); check_eq("t1_wait1", w, 1);
        send_beat(32'h0B0A0908, 4'hF, 1'b1, 1'b0, w); check_eq("t1_wait2", w, 1);
        drain();

        // 2: two half beats merge
        push_exp(32'hDDCCBBAA, 4'hF, 1'b1, 1'b1);
        send_beat(32'h0000BBAA, 4'b0011, 1'b0, 1'b0, w);
        send_beat(32'h0000DDCC, 4'b0011, 1'b1, 1'b1, w);
        drain();

        // 3: sparse lanes compacted in order
        push_exp(32'h77554422, 4'hF, 1'b1, 1'b0);
        send_beat(32'h44332211, 4'b1010, 1'b0, 1'b0, w);
        send_beat(32'h88776655, 4'b0101, 1'b1, 1'b0, w);
        drain();

        // 4: overflowing last beat produces a tail beat and one input bubble
        push_exp(32'h44332211, 4'hF, 1'b0, 1'b1);
        push_exp(32'h00776655, 4'b0111, 1'b1, 1'b1);
        send_beat(32'h00332211, 4'b0111, 1'b0, 1'b0, w);
        send_beat(32'h77665544, 4'hF, 1'b1, 1'b1, w);
        tick();
        check_eq("t4_ready_low", s_axis_tready, 0);
        tick();
        check_eq("t4_ready_back", s_axis_tready, 1);
        drain();

        // 5: empty frame, and an empty non-last beat is a no-op
        push_exp(32'h0, 4'h0, 1'b1, 1'b0);
        send_beat(32'hDEADBEEF, 4'h0, 1'b1, 1'b0, w);
        drain();
        push_exp(32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
        send_beat(32'h12345678, 4'h0, 1'b0, 1'b0, w);
        send_beat(32'hCAFEF00D, 4'hF, 1'b1, 1'b1, w);
        drain();

        // 6: random frames against the byte-queue model
        use_model = 1'b1;
        rdy_mode  = 1;
        for (int f = 0; f < 1000; f++) begin
            nb = $urandom_range(1, 6);
            for (int unsigned b = 0; b < nb; b++) begin
                k = ($urandom_range(0, 3) == 0) ? 4'hF : KW'($urandom_range(0, 15));
                send_beat($urandom, k, (b == nb - 1), 1'($urandom_range(0, 1)), w);
                if (f % 100 == 50 && b == 0) begin
                    rdy_mode = 2;
                    repeat (5) tick();
                    rdy_mode = 1;
                end
            end
        end
        drain();
        check_eq("model_bytes_left", byte_q.size(), 0);

        // 7: reset with residual bytes and a pending tail
        use_model = 1'b0;
        rdy_mode  = 2;
        push_exp(32'h44332211, 4'hF, 1'b0, 1'b0);
        send_beat(32'h00332211, 4'b0111, 1'b0, 1'b0, w);
        send_beat(32'h77665544, 4'hF, 1'b1, 1'b0, w);
        tick();
        check_eq("t7_tail_wait", s_axis_tready, 0);
        do_reset();
        use_model = 1'b1;
        rdy_mode  = 0;
        send_beat(32'hA1A2A3A4, 4'b0001, 1'b0, 1'b1, w);
        send_beat(32'hB1B2B3B4, 4'b1100, 1'b1, 1'b1, w);
        check_eq("t7_exp_count", exp_q.size(), 1);
        check_eq("t7_exp_data", exp_q[0].data, 32'h00B1B2A4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
